// File: rtl/map_pixel_source.sv
// map_pixel_source: generates the colour for the VGA driver from the SLAM
// occupancy map. It looks 3 pixels ahead of the driver's counters so the
// registered colour lands exactly on the pixel the driver is emitting.
// A robot-pose marker is overlaid, and pose updates are deferred to frame
// boundaries so the marker never tears mid-frame.
module map_pixel_source #(
  parameter int          H_MAX      = 1800,
  parameter int          V_MAX      = 1000,
  parameter int          MAP_W_LOG2 = 8,
  parameter int          MAP_H      = 225,
  parameter int          CELL_SHIFT = 2,
  parameter int          X_OFF      = 288,
  parameter int          Y_OFF      = 0,
  parameter logic [11:0] BORDER_RGB = 12'h008,
  parameter logic [11:0] MARKER_RGB = 12'hF00
) (
  input  logic        pxlClk,
  input  logic        reset,
  input  logic [13:0] hCntr,
  input  logic [13:0] vCntr,
  output logic [15:0] map_addr,
  input  logic [7:0]  map_data,
  input  logic [7:0]  pose_x,
  input  logic [7:0]  pose_y,
  input  logic        pose_strobe,
  input  logic        marker_en,
  output logic [11:0] rgb_out
);

  localparam logic [13:0] H_LIM = 14'(H_MAX);
  localparam logic [13:0] V_LIM = 14'(V_MAX);
  localparam logic [13:0] X_LO  = 14'(X_OFF);
  localparam logic [13:0] Y_LO  = 14'(Y_OFF);
  localparam logic [13:0] X_END = 14'(X_OFF + ((1 << MAP_W_LOG2) << CELL_SHIFT));
  localparam logic [13:0] Y_END = 14'(Y_OFF + (MAP_H << CELL_SHIFT));

  // Lookahead coordinates (the pixel that will be on screen 3 cycles from now)
  logic [13:0] h_sum;
  logic [13:0] v_next;
  logic [13:0] look_h;
  logic [13:0] look_v;

  // Map-space decode of the lookahead pixel
  logic        x_lo_ok;
  logic        y_lo_ok;
  logic        in_map;
  logic [13:0] h_rel;
  logic [13:0] v_rel;
  logic [7:0]  cell_x;
  logic [7:0]  cell_y;
  logic        is_marker;

  // Pipeline state
  logic        s1_valid;
  logic [13:0] s1_h;
  logic [13:0] s1_v;
  logic        s1_in_map;
  logic        s1_marker;
  logic        s2_valid;
  logic        s2_in_map;
  logic        s2_marker;
  logic        frame_start;

  // Pose handshake state
  logic [7:0]  pending_x;
  logic [7:0]  pending_y;
  logic        pending_valid;
  logic [7:0]  active_x;
  logic [7:0]  active_y;
  logic        active_valid;

  // Only the upper nibble of a cell selects the grey level.
  logic        unused_map_bits;
  assign unused_map_bits = &{1'b0, map_data[3:0]};

  // Advance the driver counters by 3 pixels, wrapping line and frame.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    h_sum  = hCntr + 14'd3;
    v_next = vCntr + 14'd1;
    look_h = h_sum;
    look_v = vCntr;
    if (h_sum >= H_LIM) begin
      look_h = h_sum - H_LIM;
      look_v = (v_next >= V_LIM) ? 14'd0 : v_next;
    end
  end

  // A zero offset makes the lower-bound compare trivially true; skip it then.
  if (X_OFF == 0) begin : g_x_lo_zero
    assign x_lo_ok = 1'b1;
  end else begin : g_x_lo_cmp
    assign x_lo_ok = (look_h >= X_LO);
  end

  if (Y_OFF == 0) begin : g_y_lo_zero
    assign y_lo_ok = 1'b1;
  end else begin : g_y_lo_cmp
    assign y_lo_ok = (look_v >= Y_LO);
  end

  // Bounds are checked before the subtraction, so a negative offset result
  // only ever feeds cells that in_map already rejects.
  assign in_map    = x_lo_ok && (look_h < X_END) && y_lo_ok && (look_v < Y_END);
  assign h_rel     = look_h - X_LO;
  assign v_rel     = look_v - Y_LO;
  assign cell_x    = 8'(h_rel >> CELL_SHIFT);
  assign cell_y    = 8'(v_rel >> CELL_SHIFT);
  assign is_marker = marker_en && active_valid && in_map &&
                     (cell_x == active_x) && (cell_y == active_y);

  // The frame boundary is the cycle when stage 1 holds pixel (0,0).
  assign frame_start = s1_valid && (s1_h == 14'd0) && (s1_v == 14'd0);

  // Stage 1: latch lookahead pixel, issue the BRAM read, decide marker.
  always_ff @(posedge pxlClk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_h      <= '0;
      s1_v      <= '0;
      s1_in_map <= 1'b0;
      s1_marker <= 1'b0;
      map_addr  <= '0;
    end else begin
      s1_valid  <= 1'b1;
      s1_h      <= look_h;
      s1_v      <= look_v;
      s1_in_map <= in_map;
      s1_marker <= is_marker;
      if (in_map) begin
        map_addr <= 16'({cell_y, cell_x[MAP_W_LOG2-1:0]});
      end
    end
  end

  // Stage 2: wait out the BRAM read latency alongside the pixel flags.
  always_ff @(posedge pxlClk) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_in_map <= 1'b0;
      s2_marker <= 1'b0;
    end else begin
      s2_valid  <= s1_valid;
      s2_in_map <= s1_in_map;
      s2_marker <= s1_marker;
    end
  end

  // Stage 3: pick border, marker or inverted-occupancy grey.
  always_ff @(posedge pxlClk) begin
    if (reset) begin
      rgb_out <= '0;
    end else if (!s2_valid) begin
      rgb_out <= '0;
    end else if (!s2_in_map) begin
      rgb_out <= BORDER_RGB;
    end else if (s2_marker) begin
      rgb_out <= MARKER_RGB;
    end else begin
      rgb_out <= {~map_data[7:4], ~map_data[7:4], ~map_data[7:4]};
    end
  end

  // Pose handshake: strobes land in pending; pending moves to active at frame start.
  always_ff @(posedge pxlClk) begin
    if (reset) begin
      pending_x     <= '0;
      pending_y     <= '0;
      pending_valid <= 1'b0;
      active_x      <= '0;
      active_y      <= '0;
      active_valid  <= 1'b0;
    end else begin
      if (frame_start && pending_valid) begin
        active_x      <= pending_x;
        active_y      <= pending_y;
        active_valid  <= 1'b1;
        pending_valid <= 1'b0;
      end
      // A strobe on the boundary cycle still becomes pending for the next frame.
      if (pose_strobe) begin
        pending_x     <= pose_x;
        pending_y     <= pose_y;
        pending_valid <= 1'b1;
      end
    end
  end

endmodule
